// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    // EX operand source selects
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam int DEF_REG_AW = 5;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of hazard-controller signals between the datapath and the controller.
interface pipe_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_memread;
    logic              ex_branch_taken;
    logic              mem_req;
    logic              dmem_ready;
    logic              exmem_regwrite;
    logic [REG_AW-1:0] exmem_rd;
    logic              memwb_regwrite;
    logic [REG_AW-1:0] memwb_rd;
    logic              cnt_clr;

    logic              pc_we;
    logic              ifid_we;
    logic              ifid_flush;
    logic              idex_we;
    logic              idex_flush;
    logic              exmem_we;
    logic              memwb_we;
    logic              memwb_bubble;
    logic [1:0]        forward_a;
    logic [1:0]        forward_b;
    logic              mem_err;
    logic [CNT_W-1:0]  stall_cnt;

    // Datapath side: supplies pipeline status, consumes enables/selects
    modport master (
        output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_memread, ex_branch_taken,
               mem_req, dmem_ready, exmem_regwrite, exmem_rd, memwb_regwrite,
               memwb_rd, cnt_clr,
        input  pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we,
               memwb_we, memwb_bubble, forward_a, forward_b, mem_err, stall_cnt
    );

    // Controller side
    modport slave (
        input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_memread, ex_branch_taken,
               mem_req, dmem_ready, exmem_regwrite, exmem_rd, memwb_regwrite,
               memwb_rd, cnt_clr,
        output pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we,
               memwb_we, memwb_bubble, forward_a, forward_b, mem_err, stall_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd.sv
// EX-stage operand forwarding select; EX_MEM result wins over MEM_WB.
module pipe_fwd_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic              exmem_regwrite,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              memwb_regwrite,
    input  logic [REG_AW-1:0] memwb_rd,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b
);

    // r0 is hardwired zero, so a write to it never forwards
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic              em_wr,
        input logic [REG_AW-1:0] em_rd,
        input logic              mw_wr,
        input logic [REG_AW-1:0] mw_rd
    );
        if (em_wr && (em_rd != '0) && (em_rd == rs))
            return FWD_EXMEM;
        else if (mw_wr && (mw_rd != '0) && (mw_rd == rs))
            return FWD_MEMWB;
        else
            return FWD_REG;
    endfunction

    // Both operand selects from the same rule
    always_comb begin
        forward_a = fwd_sel(ex_rs1, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);
        forward_b = fwd_sel(ex_rs2, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stage enables/flushes for load-use, taken branches and
// data-memory waits (with timeout), plus forwarding selects and a stall counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW  = DEF_REG_AW,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W:0] TIMEOUT_V = TIMEOUT[WAIT_W:0];

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W:0]   wait_next;
    logic              mem_err_q;
    logic [CNT_W-1:0]  stall_q;

    logic              mem_wait;
    logic              load_use;
    logic [1:0]        fwd_a_raw;
    logic [1:0]        fwd_b_raw;

    logic pc_we, ifid_we, ifid_flush, idex_we, idex_flush;
    logic exmem_we, memwb_we, memwb_bubble;

    assign mem_wait  = bus.mem_req & ~bus.dmem_ready;
    assign load_use  = bus.ex_memread && (bus.ex_rd != '0) &&
                       ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));
    assign wait_next = {1'b0, wait_cnt} + 1'b1;

    pipe_fwd_unit #(.REG_AW(REG_AW)) u_fwd (
        .ex_rs1         (bus.ex_rs1),
        .ex_rs2         (bus.ex_rs2),
        .exmem_regwrite (bus.exmem_regwrite),
        .exmem_rd       (bus.exmem_rd),
        .memwb_regwrite (bus.memwb_regwrite),
        .memwb_rd       (bus.memwb_rd),
        .forward_a      (fwd_a_raw),
        .forward_b      (fwd_b_raw)
    );

    // Stage enables/flushes: reset > error freeze > dmem freeze > branch > load-use
    always_comb begin
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_we      = 1'b1;
        idex_flush   = 1'b0;
        exmem_we     = 1'b1;
        memwb_we     = 1'b1;
        memwb_bubble = 1'b0;
        if (rst) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            ifid_flush   = 1'b1;
            idex_we      = 1'b0;
            idex_flush   = 1'b1;
            exmem_we     = 1'b0;
            memwb_we     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (state == ERR) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_we     = 1'b0;
            memwb_we     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (mem_wait) begin
            // Front of the pipe holds; MEM_WB keeps draining bubbles
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_we     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (bus.ex_branch_taken) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
        end else if (load_use) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_flush   = 1'b1;
        end
    end

    // Sequencer: tracks dmem wait length and latches the timeout error
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_wait) begin
                        wait_cnt <= WAIT_W'(1);
                        if (TIMEOUT_V <= 1) begin
                            state     <= ERR;
                            mem_err_q <= 1'b1;
                        end else begin
                            state <= MEM_WAIT;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (mem_wait) begin
                        wait_cnt <= wait_next[WAIT_W-1:0];
                        if (wait_next >= TIMEOUT_V) begin
                            state     <= ERR;
                            mem_err_q <= 1'b1;
                        end
                    end else begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end
                end
                ERR: begin
                    mem_err_q <= 1'b1;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Saturating count of PC-stalled cycles; clear beats increment
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (bus.cnt_clr) begin
            stall_q <= '0;
        end else if ((state != ERR) && !pc_we && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.pc_we        = pc_we;
    assign bus.ifid_we      = ifid_we;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_we      = idex_we;
    assign bus.idex_flush   = idex_flush;
    assign bus.exmem_we     = exmem_we;
    assign bus.memwb_we     = memwb_we;
    assign bus.memwb_bubble = memwb_bubble;
    assign bus.forward_a    = rst ? FWD_REG : fwd_a_raw;
    assign bus.forward_b    = rst ? FWD_REG : fwd_b_raw;
    assign bus.mem_err      = mem_err_q;
    assign bus.stall_cnt    = stall_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC.
- Generates per-stage write-enables and flushes for the following cases:
  - load-use stalls
  - taken-branch flushes
  - multi-cycle data-memory waits, including a timeout watchdog
- Provides EX-stage forwarding selects and a saturating stall-cycle counter.
- Sits beside the datapath; all stage registers take their we/flush from this block.

Parameters:
REG_AW, 5, register-address width
TIMEOUT, 255, max consecutive dmem wait cycles before error (>=1)
CNT_W, 32, stall counter width

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  synchronous active-high reset
id_rs1  input  REG_AW  source reg 1 of instruction in ID
id_rs2  input  REG_AW  source reg 2 of instruction in ID
ex_rs1  input  REG_AW  source reg 1 of instruction in EX
ex_rs2  input  REG_AW  source reg 2 of instruction in EX
ex_rd  input  REG_AW  destination of instruction in EX
ex_memread  input  1  EX instruction is a load
ex_branch_taken  input  1  EX resolved a taken branch
mem_req  input  1  MEM stage accesses data memory (memread|memwrite)
dmem_ready  input  1  data memory completes access this cycle
exmem_regwrite  input  1  EX_MEM regwrite
exmem_rd  input  REG_AW  EX_MEM destination
memwb_regwrite  input  1  MEM_WB regwrite
memwb_rd  input  REG_AW  MEM_WB destination
cnt_clr  input  1  clear stall counter
pc_we  output  1  PC update enable
ifid_we  output  1  IF_ID load enable
ifid_flush  output  1  IF_ID clear to bubble
idex_we  output  1  ID_EX load enable
idex_flush  output  1  ID_EX clear to bubble
exmem_we  output  1  EX_MEM load enable
memwb_we  output  1  MEM_WB load enable
memwb_bubble  output  1  MEM_WB loads regwrite=0, memtoreg=0
forward_a  output  2  EX operand A select: 00 regfile, 10 EX_MEM, 01 MEM_WB
forward_b  output  2  EX operand B select, same encoding
mem_err  output  1  sticky dmem timeout flag
stall_cnt  output  CNT_W  cycles with pc_we=0 outside reset/ERR

Behaviour:
Registered state and outputs:
- Registered: state (RUN, MEM_WAIT, ERR), wait counter, mem_err, stall_cnt.
- All other outputs are combinational from state and inputs, acting in the same cycle.

While rst=1:
- All *_we=0, ifid_flush=1, idex_flush=1, memwb_bubble=1, forward_*=00.
- Next state RUN; wait counter 0, mem_err 0, stall_cnt 0.

Wait condition:
- mem_wait = mem_req & ~dmem_ready.

RUN state:
- If mem_wait:
  - pc_we, ifid_we, idex_we, exmem_we = 0.
  - memwb_we=1 with memwb_bubble=1.
  - Wait counter <= 1; go to MEM_WAIT.
  - Branch and load-use are ignored this cycle.
- Else, default is all we=1 and no flush.
  - If ex_branch_taken: ifid_flush=1, idex_flush=1; pc_we=1 loads the target.
  - Else if load-use: pc_we=0, ifid_we=0, idex_flush=1. Load-use = ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - Branch has priority over load-use.

MEM_WAIT state:
- Request held stable, because EX_MEM is frozen.
- While mem_wait:
  - Same freeze as entry.
  - Wait counter increments.
  - When the counter reaches TIMEOUT with dmem still not ready: go to ERR and set mem_err=1.
- When dmem_ready=1 (release cycle):
  - Evaluate exactly as RUN without mem_wait: normal advance plus branch/load-use rules.
  - Return to RUN; wait counter <= 0.
- dmem_ready in the first cycle of a request never enters MEM_WAIT (zero stall).

ERR state:
- All we=0, memwb_bubble=1, pipeline frozen.
- mem_err held at 1; only rst exits.

Forwarding (all states):
- forward_a = 10 if exmem_regwrite & exmem_rd!=0 & exmem_rd==ex_rs1.
- Else 01 if memwb_regwrite & memwb_rd!=0 & memwb_rd==ex_rs1.
- Else 00.
- EX_MEM has priority over MEM_WB. forward_b uses the same rule with ex_rs2.

stall_cnt:
- +1 on every non-reset, non-ERR cycle with pc_we=0.
- Saturates at all-ones.
- cnt_clr sets it to 0, with priority over the increment.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state enum {RUN, MEM_WAIT, ERR}
  - FWD_REG=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01
  - default REG_AW
- Sub-module pipe_fwd_unit: purely combinational forwarding select, instantiated once and producing both forward_a and forward_b.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs2=5 for one cycle -> pc_we=0, ifid_we=0, idex_flush=1; stall_cnt 0->1; next cycle all we=1.
- Branch vs load-use: ex_branch_taken=1 with a load-use hazard present -> ifid_flush=1, idex_flush=1, pc_we=1; stall_cnt unchanged.
- Dmem wait: mem_req=1, dmem_ready=0 for 3 cycles then 1 -> exmem_we=0 and memwb_bubble=1 for 3 cycles, then all we=1; stall_cnt=3; state back to RUN.
- Timeout: TIMEOUT=4, mem_req=1, dmem_ready held 0 -> mem_err=1 after 4 wait cycles, all we=0 indefinitely; rst=1 for one cycle -> mem_err=0, state RUN.
- Forwarding: exmem(rd=3, regwrite=1) and memwb(rd=3, regwrite=1), ex_rs1=3 -> forward_a=10; with exmem_rd=0 -> forward_a=01; with memwb_regwrite=0 too -> forward_a=00.
- Reset mid-wait plus counter: rst asserted during MEM_WAIT -> next cycle state RUN, stall_cnt=0. Counter check: preload stall_cnt near all-ones with CNT_W=4, stall 20 cycles -> stays 15; cnt_clr=1 -> 0.
